// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The optional stall counter is enabled by PIPELINE_STALL_CTRL_PERF_EN.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MC  = 1'b1
  } state_t;

  localparam int MC_CNT_W      = 4;
  localparam int REG_ADDR_ZERO = 0;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline <-> stall controller signal bundle; master = pipeline, slave = controller.
// Adds stall_cycles when PIPELINE_STALL_CTRL_PERF_EN is defined.
interface pipeline_stall_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    import pipe_ctrl_pkg::*;

    // No handshake: every control is level-sampled each clk cycle and every
    // output is valid in the same cycle as the inputs that produced it.
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mc_start;
    logic                  branch_taken;
    logic                  ext_stall;

    logic                  pc_we;
    logic                  if_id_we;
    logic                  id_ex_we;
    logic                  ex_mem_we;
    logic                  mem_wb_we;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic                  mc_busy;
    state_t                dbg_state;
`ifdef PIPELINE_STALL_CTRL_PERF_EN
    logic [31:0]           stall_cycles;
`endif

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_reg_write,
               ex_mem_read, ex_mc_start, branch_taken, ext_stall,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, ex_mem_flush, mc_busy, dbg_state
`ifdef PIPELINE_STALL_CTRL_PERF_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_reg_write,
               ex_mem_read, ex_mc_start, branch_taken, ext_stall,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, ex_mem_flush, mc_busy, dbg_state
`ifdef PIPELINE_STALL_CTRL_PERF_EN
        , output stall_cycles
`endif
    );

endinterface

// File: rtl/pipeline_stall_ctrl_load_use.sv
// Combinational load-use hazard compare between the ID sources and the EX load.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    output logic                  hazard
);

    logic rd_live;
    logic src_match;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign rd_live   = ex_mem_read && ex_reg_write &&
                       (ex_rd != REG_ADDR_W'(REG_ADDR_ZERO));
    assign src_match = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd));
    assign hazard    = rd_live && src_match;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, multi-cycle EX,
// branch squash, external freeze. PIPELINE_STALL_CTRL_PERF_EN adds stall_cycles.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LAT     = 4
) (
    input logic                 clk,
    input logic                 nReset,
    pipeline_stall_ctrl_if.slave ctl
);

    localparam bit                    MC_EN   = (MC_LAT > 1);
    localparam logic [MC_CNT_W-1:0]   MC_LOAD = MC_CNT_W'(MC_EN ? MC_LAT - 2 : 0);

    state_t              state;
    logic [MC_CNT_W-1:0] mc_cnt;
    logic                hazard;
    logic                mc_start;
    logic [4:0]          we;     // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0]          flush;  // {if_id, id_ex, ex_mem}
    logic                busy;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use (
        .id_rs1       (ctl.id_rs1),
        .id_rs2       (ctl.id_rs2),
        .id_uses_rs1  (ctl.id_uses_rs1),
        .id_uses_rs2  (ctl.id_uses_rs2),
        .ex_rd        (ctl.ex_rd),
        .ex_reg_write (ctl.ex_reg_write),
        .ex_mem_read  (ctl.ex_mem_read),
        .hazard       (hazard)
    );

    assign mc_start = MC_EN && ctl.ex_mc_start;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state  <= ST_RUN;
            mc_cnt <= '0;
        end else if (!ctl.ext_stall) begin
            case (state)
                ST_RUN: begin
                    if (mc_start) begin
                        state  <= ST_MC;
                        mc_cnt <= MC_LOAD;
                    end
                end
                ST_MC: begin
                    if (mc_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        mc_cnt <= mc_cnt - MC_CNT_W'(1);
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        we    = 5'b11111;
        flush = 3'b000;
        busy  = (state == ST_MC);
        if (ctl.ext_stall) begin
            we = 5'b00000;
        end else if (state == ST_MC) begin
            if (mc_cnt != '0) begin
                we = 5'b00001;
            end
        end else if (mc_start) begin
            // EX/MEM takes a bubble now so MEM/WB replays it while the front is held.
            we    = 5'b00011;
            flush = 3'b001;
            busy  = 1'b1;
        end else if (ctl.branch_taken) begin
            flush = 3'b110;
        end else if (hazard) begin
            we    = 5'b00111;
            flush = 3'b010;
        end
        if (!nReset) begin
            we    = 5'b00000;
            flush = 3'b000;
            busy  = 1'b0;
        end
    end

    assign ctl.pc_we        = we[4];
    assign ctl.if_id_we     = we[3];
    assign ctl.id_ex_we     = we[2];
    assign ctl.ex_mem_we    = we[1];
    assign ctl.mem_wb_we    = we[0];
    assign ctl.if_id_flush  = flush[2];
    assign ctl.id_ex_flush  = flush[1];
    assign ctl.ex_mem_flush = flush[0];
    assign ctl.mc_busy      = busy;
    assign ctl.dbg_state    = state;

`ifdef PIPELINE_STALL_CTRL_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            stall_cnt <= '0;
        end else if (!we[4] && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign ctl.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl against an occupancy-based reference model.
module tb_pipeline_stall_ctrl;

  localparam int W      = 5;
  localparam int MC_LAT = 4;

  // Expected/observed vector: {pc, if_id, id_ex, ex_mem, mem_wb we, if_id, id_ex, ex_mem flush, busy}
  localparam logic [8:0] V_RUN    = 9'b11111_000_0;
  localparam logic [8:0] V_LU     = 9'b00111_010_0;
  localparam logic [8:0] V_BR     = 9'b11111_110_0;
  localparam logic [8:0] V_ZERO   = 9'b00000_000_0;

  logic clk;
  logic nReset;
  int   n_cmp;
  int   n_fail;

  // Reference model: an active multi-cycle op and the EX cycles it has already used.
  bit          op_active;
  int          op_used;
  logic [31:0] stall_exp;
  logic [8:0]  exp_q[$];

  pipeline_stall_ctrl_if #(.REG_ADDR_W(W)) bus ();

  pipeline_stall_ctrl #(
    .REG_ADDR_W (W),
    .MC_LAT     (MC_LAT)
  ) dut (
    .clk    (clk),
    .nReset (nReset),
    .ctl    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] observed();
    return {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we,
            bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mc_busy};
  endfunction

  function automatic logic [8:0] model_out();
    bit lu;
    if (!nReset) return V_ZERO;
    lu = bus.ex_mem_read && bus.ex_reg_write && (bus.ex_rd != 0) &&
         ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
          (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    if (bus.ext_stall) return {8'b0, op_active};
    if (op_active) begin
      if (op_used < MC_LAT - 1) return 9'b00001_000_1;
      return 9'b11111_000_1;
    end
    if (bus.ex_mc_start && MC_LAT > 1) return 9'b00011_001_1;
    if (bus.branch_taken) return V_BR;
    if (lu) return V_LU;
    return V_RUN;
  endfunction

  task automatic model_reset();
    op_active = 1'b0;
    op_used   = 0;
    stall_exp = '0;
  endtask

  task automatic model_advance();
    logic [8:0] e;
    if (!nReset) begin
      model_reset();
      return;
    end
    e = model_out();
    if (!e[8] && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 1;
    if (bus.ext_stall) return;
    if (op_active) begin
      if (op_used >= MC_LAT - 1) op_active = 1'b0;
      else op_used = op_used + 1;
    end else if (bus.ex_mc_start && MC_LAT > 1) begin
      op_active = 1'b1;
      op_used   = 1;
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_rd = '0; bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
    bus.ex_mc_start = 1'b0; bus.branch_taken = 1'b0; bus.ext_stall = 1'b0;
  endtask

  task automatic set_load_use(input logic [W-1:0] rd);
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = rd;
    bus.id_rs2 = rd; bus.id_uses_rs2 = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] o;
    nReset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1 o = observed();
      n_cmp++;
      if (o !== V_ZERO) begin
        n_fail++; $display("FAIL reset_hold[%0d]: got %b want %b", i, o, V_ZERO);
      end
      tick();
    end
    nReset = 1'b1;
    #1 o = observed();
    n_cmp++;
    if (o !== V_RUN) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", o, V_RUN);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [8:0] o;
    set_load_use(5'd5);
    #1 o = observed();
    n_cmp++;
    if (o !== V_LU || o !== model_out()) begin
      n_fail++; $display("FAIL load_use_stall: got %b want %b", o, V_LU);
    end
    tick();
    set_idle();
    #1 o = observed();
    n_cmp++;
    if (o !== V_RUN) begin
      n_fail++; $display("FAIL load_use_after: got %b want %b", o, V_RUN);
    end
    tick();
    set_load_use(5'd0);
    #1 o = observed();
    n_cmp++;
    if (o !== V_RUN) begin
      n_fail++; $display("FAIL load_use_x0: got %b want %b", o, V_RUN);
    end
    tick();
    set_idle();
  endtask

  task automatic test_branch_load_use();
    logic [8:0] o;
    set_load_use(5'd7);
    bus.branch_taken = 1'b1;
    #1 o = observed();
    n_cmp++;
    if (o !== V_BR) begin
      n_fail++; $display("FAIL branch_over_lu: got %b want %b", o, V_BR);
    end
    tick();
    set_idle();
  endtask

  task automatic test_mc(input bit with_stall);
    logic [8:0] o;
    int n_pc0, n_bub, n_busy, n_brf, want_pc0;
    n_pc0 = 0; n_bub = 0; n_busy = 0; n_brf = 0;
    want_pc0 = with_stall ? MC_LAT + 1 : MC_LAT - 1;
    for (int c = 0; c < 9; c++) begin
      bus.ex_mc_start  = (c == 0);
      bus.branch_taken = (c >= 1 && c <= 3);
      bus.ext_stall    = with_stall && (c == 2 || c == 3);
      if (c >= 1 && c <= 3) set_load_use(5'd3);
      else begin
        bus.ex_mem_read = 1'b0; bus.id_uses_rs2 = 1'b0;
      end
      if (!with_stall && c >= 4) bus.branch_taken = 1'b0;
      if (with_stall) bus.branch_taken = 1'b0;
      #1 o = observed();
      n_cmp++;
      if (o !== model_out()) begin
        n_fail++; $display("FAIL mc_cycle[%0d] stall=%0d: got %b want %b", c, with_stall, o, model_out());
      end
      if (!o[8]) n_pc0++;
      if (o[1]) n_bub++;
      if (o[0]) n_busy++;
      if (o[3]) n_brf++;
      tick();
    end
    set_idle();
    n_cmp++;
    if (n_pc0 != want_pc0) begin
      n_fail++; $display("FAIL mc_freeze_len: got %0d want %0d", n_pc0, want_pc0);
    end
    n_cmp++;
    if (n_bub != 1) begin
      n_fail++; $display("FAIL mc_bubble_count: got %0d want 1", n_bub);
    end
    n_cmp++;
    if (n_busy != (with_stall ? MC_LAT + 2 : MC_LAT)) begin
      n_fail++; $display("FAIL mc_busy_len: got %0d want %0d", n_busy, with_stall ? MC_LAT + 2 : MC_LAT);
    end
    n_cmp++;
    if (n_brf != 0) begin
      n_fail++; $display("FAIL mc_branch_ignored: got %0d flushes want 0", n_brf);
    end
  endtask

  task automatic test_reset_mid_mc();
    logic [8:0] o;
    bus.ex_mc_start = 1'b1;
    tick();
    bus.ex_mc_start = 1'b0;
    nReset = 1'b0;
    model_reset();
    tick();
    nReset = 1'b1;
    #1 o = observed();
    n_cmp++;
    if (o !== V_RUN) begin
      n_fail++; $display("FAIL reset_mid_mc: got %b want %b", o, V_RUN);
    end
`ifdef PIPELINE_STALL_CTRL_PERF_EN
    n_cmp++;
    if (bus.stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_mc_perf: got %0d want 0", bus.stall_cycles);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    logic [8:0] o;
    logic [8:0] e;
    for (int i = 0; i < 400; i++) begin
      bus.ext_stall    = ($urandom_range(0, 7) == 0);
      bus.ex_mc_start  = ($urandom_range(0, 9) == 0);
      bus.branch_taken = ($urandom_range(0, 5) == 0);
      bus.id_rs1       = W'($urandom_range(0, 3));
      bus.id_rs2       = W'($urandom_range(0, 3));
      bus.ex_rd        = W'($urandom_range(0, 3));
      bus.id_uses_rs1  = 1'($urandom_range(0, 1));
      bus.id_uses_rs2  = 1'($urandom_range(0, 1));
      bus.ex_reg_write = 1'($urandom_range(0, 1));
      bus.ex_mem_read  = 1'($urandom_range(0, 1));
      nReset           = ($urandom_range(0, 49) != 0);
      if (!nReset) model_reset();
      #1 exp_q.push_back(model_out());
      o = observed();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL random[%0d]: got %b want %b", i, o, e);
      end
`ifdef PIPELINE_STALL_CTRL_PERF_EN
      n_cmp++;
      if (bus.stall_cycles !== stall_exp) begin
        n_fail++; $display("FAIL random_perf[%0d]: got %0d want %0d", i, bus.stall_cycles, stall_exp);
      end
`endif
      tick();
    end
    nReset = 1'b1;
    set_idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    set_idle();
    nReset = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mc(1'b0);
    test_mc(1'b1);
    test_reset_mid_mc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
